sdram_rr_arbiter: RTL and testbench

//  N-channel Wishbone-to-SDRAM-controller arbiter with round-robin grant and bounded burst tenure.
//  It sits between the DMA/CPU Wishbone masters and the sdram_controller user interface.
//  It allows one outstanding transfer at a time and issues one in_valid pulse per transfer.
//  It replaces the fixed-priority 4-port arbiter with a parametrised, starvation-free one.

---
 rtl/sdram_rr_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_sdram_rr_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_rr_arbiter.sv
// Round-robin Wishbone-to-SDRAM-controller arbiter with bounded burst tenure.
// Optional read-response watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_rr_arbiter #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned AW        = 23,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    wb_cyc_i,
  input  logic [NUM_CH-1:0]    wb_stb_i,
  input  logic [NUM_CH-1:0]    wb_we_i,
  input  logic [4*NUM_CH-1:0]  wb_sel_i,
  input  logic [32*NUM_CH-1:0] wb_adr_i,
  input  logic [DW*NUM_CH-1:0] wb_dat_i,
  output logic [NUM_CH-1:0]    wb_ack_o,
  output logic [NUM_CH-1:0]    wb_err_o,
  output logic [DW-1:0]        wb_dat_o,
  output logic [NUM_CH-1:0]    grant_o,
  output logic [AW-1:0]        ctrl_addr,
  output logic                 ctrl_rw,
  output logic [DW-1:0]        ctrl_data_in,
  output logic [3:0]           ctrl_mask,
  output logic                 ctrl_in_valid,
  input  logic                 ctrl_busy,
  input  logic                 ctrl_out_valid,
  input  logic [DW-1:0]        ctrl_data_out
);

  localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BW = 8;

  if (NUM_CH < 2 || NUM_CH > 8 || MAX_BURST < 1 || MAX_BURST > 255 || TIMEOUT < 1 || AW > 31)
  begin : g_bad_param
    $error("sdram_rr_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, GRANT, RD_WAIT} state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d, gsel, req;
  logic [IW-1:0]     owner_q, owner_d, rr_ptr, rr_ptr_d, nxt_ptr;
  logic [BW-1:0]     burst_cnt, burst_d, burst_inc;
  logic              rd_pend, rd_pend_d;
  logic              in_valid_c, ack_c, err_c, release_c, others_c;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt, tmo_d;
`endif

  // Owner mux; everything reads as zero while idle or in reset
  logic              o_cyc, o_stb, o_we, unused_adr;
  logic [3:0]        o_sel;
  logic [AW-1:0]     o_adr;
  logic [DW-1:0]     o_dat;

  assign gsel = grant_q & {NUM_CH{rst_n}};
  assign req  = wb_cyc_i & wb_stb_i;

  always_comb begin
    o_cyc      = 1'b0;
    o_stb      = 1'b0;
    o_we       = 1'b0;
    o_sel      = '0;
    o_adr      = '0;
    o_dat      = '0;
    unused_adr = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      unused_adr = unused_adr ^ (^wb_adr_i[32*c+AW +: 32-AW]);
      if (gsel[c]) begin
        o_cyc = wb_cyc_i[c];
        o_stb = wb_stb_i[c];
        o_we  = wb_we_i[c];
        o_sel = wb_sel_i[4*c +: 4];
        o_adr = wb_adr_i[32*c +: AW];
        o_dat = wb_dat_i[DW*c +: DW];
      end
    end
  end

  // Round-robin pick: first requester at or after rr_ptr, wrapping
  logic [2*NUM_CH-1:0] req2;
  logic [NUM_CH-1:0]   rot;
  logic [IW-1:0]       off, pick;
  logic [IW:0]         sum;
  logic                found;

  always_comb begin
    req2  = {req, req};
    rot   = req2[rr_ptr +: NUM_CH];
    found = 1'b0;
    off   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = IW'(i);
      end
    end
    sum = (IW+1)'(rr_ptr) + (IW+1)'(off);
    if (sum >= (IW+1)'(NUM_CH)) sum = sum - (IW+1)'(NUM_CH);
    pick = IW'(sum);
  end

  assign nxt_ptr   = (owner_q == IW'(NUM_CH - 1)) ? '0 : owner_q + IW'(1);
  assign others_c  = |(req & ~grant_q);
  assign burst_inc = (burst_cnt == BW'(MAX_BURST)) ? burst_cnt : burst_cnt + BW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      rd_pend   <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      rr_ptr    <= rr_ptr_d;
      burst_cnt <= burst_d;
      rd_pend   <= rd_pend_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
      tmo_cnt   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr;
    burst_d    = burst_cnt;
    rd_pend_d  = rd_pend;
    in_valid_c = 1'b0;
    ack_c      = 1'b0;
    err_c      = 1'b0;
    release_c  = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
    tmo_d      = tmo_cnt;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = NUM_CH'(1) << pick;
          owner_d = pick;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!o_cyc) begin
          release_c = 1'b1;
        end else if (o_we) begin
          in_valid_c = o_stb & ~ctrl_busy;
          ack_c      = in_valid_c;
        end else if (o_stb && !ctrl_busy && !rd_pend) begin
          in_valid_c = 1'b1;
          rd_pend_d  = 1'b1;
          state_d    = RD_WAIT;
`ifdef SDRAM_ARB_TIMEOUT_EN
          tmo_d      = '0;
`endif
        end
      end
      RD_WAIT: begin
        if (ctrl_out_valid) begin
          rd_pend_d = 1'b0;
          // Abandoned reads swallow the response without an ack
          if (o_cyc) begin
            ack_c   = 1'b1;
            state_d = GRANT;
          end else begin
            release_c = 1'b1;
          end
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          err_c     = o_cyc;
          rd_pend_d = 1'b0;
          release_c = 1'b1;
        end else begin
          tmo_d = tmo_cnt + TW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (ack_c || err_c) burst_d = burst_inc;
    if (ack_c && burst_inc == BW'(MAX_BURST) && others_c) release_c = 1'b1;
    if (release_c) begin
      state_d  = IDLE;
      grant_d  = '0;
      rr_ptr_d = nxt_ptr;
      burst_d  = '0;
    end
  end

  assign grant_o       = grant_q;
  assign ctrl_addr     = o_adr;
  assign ctrl_rw       = o_we;
  assign ctrl_data_in  = o_dat;
  assign ctrl_mask     = o_sel & {4{o_we}};
  assign ctrl_in_valid = in_valid_c;
  assign wb_ack_o      = ack_c ? gsel : '0;
  assign wb_dat_o      = ack_c ? ctrl_data_out : '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
  assign wb_err_o      = err_c ? gsel : '0;
`else
  assign wb_err_o      = '0;
`endif

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Directed self-checking bench for sdram_rr_arbiter (4 channels, MAX_BURST=2).
// The timeout section only runs when SDRAM_ARB_TIMEOUT_EN is defined.
module tb_sdram_rr_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   cyc, stb, we;
  logic [15:0]  sel;
  logic [127:0] adr, dat;
  logic [3:0]   ack, err, grant;
  logic [31:0]  rdat, c_addr32, c_din, c_dout;
  logic [22:0]  c_addr;
  logic         c_rw, c_iv, c_busy, c_ov;
  logic [3:0]   c_mask;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sdram_rr_arbiter #(.NUM_CH(4), .AW(23), .DW(32), .MAX_BURST(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_adr_i(adr), .wb_dat_i(dat),
    .wb_ack_o(ack), .wb_err_o(err), .wb_dat_o(rdat), .grant_o(grant),
    .ctrl_addr(c_addr), .ctrl_rw(c_rw), .ctrl_data_in(c_din), .ctrl_mask(c_mask),
    .ctrl_in_valid(c_iv), .ctrl_busy(c_busy), .ctrl_out_valid(c_ov),
    .ctrl_data_out(c_dout)
  );

  assign c_addr32 = {9'd0, c_addr};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic v, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d);
    cyc[c] = v;
    stb[c] = v;
    we[c]  = w;
    sel[4*c +: 4]  = s;
    adr[32*c +: 32] = a;
    dat[32*c +: 32] = d;
  endtask

  logic [3:0] exp_ack [15];
  int n_iv, n_ack, n_err;
  logic held;

  initial begin
    rst_n = 1'b0; cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; dat = '0;
    c_busy = 1'b0; c_ov = 1'b0; c_dout = '0;
    tick(); tick(); #1;
    chk("reset_grant", 64'(grant), 64'h0);
    chk("reset_ack", 64'(ack), 64'h0);
    chk("reset_in_valid", 64'(c_iv), 64'h0);
    tick(); rst_n = 1'b1; #1;

    // Single write on channel 1
    set_ch(1, 1'b1, 1'b1, 4'b0110, 32'h10, 32'hA5A5_0001); #1;
    chk("wr_idle_grant", 64'(grant), 64'h0);
    tick(); #1;
    chk("wr_grant", 64'(grant), 64'b0010);
    chk("wr_in_valid", 64'(c_iv), 64'h1);
    chk("wr_ack", 64'(ack), 64'b0010);
    chk("wr_addr", 64'(c_addr32), 64'h10);
    chk("wr_data", 64'(c_din), 64'hA5A5_0001);
    chk("wr_mask", 64'(c_mask), 64'b0110);
    chk("wr_rw", 64'(c_rw), 64'h1);
    chk("wr_err", 64'(err), 64'h0);
    tick(); set_ch(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("wr_drop_ack", 64'(ack), 64'h0);
    tick(); #1;
    chk("wr_release", 64'(grant), 64'h0);

    // Read on channel 2 with 6-cycle controller latency
    set_ch(2, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    tick(); #1;
    chk("rd_grant", 64'(grant), 64'b0100);
    chk("rd_mask", 64'(c_mask), 64'h0);
    chk("rd_addr", 64'(c_addr32), 64'h20);
    n_iv = int'(c_iv); n_ack = 0;
    for (int k = 1; k <= 5; k++) begin
      tick(); #1;
      n_iv  += int'(c_iv);
      n_ack += (ack != 4'b0000) ? 1 : 0;
    end
    chk("rd_early_ack", 64'(n_ack), 64'h0);
    tick(); c_ov = 1'b1; c_dout = 32'h1234_5678; #1;
    n_iv += int'(c_iv);
    chk("rd_ack", 64'(ack), 64'b0100);
    chk("rd_data", 64'(rdat), 64'h1234_5678);
    chk("rd_one_in_valid", 64'(n_iv), 64'h1);
    tick(); c_ov = 1'b0; set_ch(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("rd_after_ack", 64'(ack), 64'h0);
    tick(); #1;

    // Busy stall on channel 0 (rr_ptr now 3, wraps to 0)
    set_ch(0, 1'b1, 1'b1, 4'hF, 32'h40, 32'hDEAD_0000); c_busy = 1'b1;
    tick(); #1;
    chk("busy_grant", 64'(grant), 64'b0001);
    n_ack = 0; n_iv = 0;
    for (int k = 0; k < 10; k++) begin
      n_ack += (ack != 4'b0000) ? 1 : 0;
      n_iv  += int'(c_iv);
      tick(); #1;
    end
    chk("busy_no_ack", 64'(n_ack), 64'h0);
    chk("busy_no_in_valid", 64'(n_iv), 64'h0);
    c_busy = 1'b0; #1;
    chk("busy_release_ack", 64'(ack), 64'b0001);
    chk("busy_release_iv", 64'(c_iv), 64'h1);
    tick(); set_ch(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick(); #1;

    // Channel 3 alone: 20 writes, grant never released
    set_ch(3, 1'b1, 1'b1, 4'hF, 32'h80, 32'h3333_3333); #1;
    chk("solo_idle_ack", 64'(ack), 64'h0);
    tick(); #1;
    n_ack = 0; held = 1'b1;
    for (int k = 0; k < 20; k++) begin
      n_ack += (ack == 4'b1000) ? 1 : 0;
      if (grant != 4'b1000) held = 1'b0;
      if (k < 19) begin tick(); #1; end
    end
    chk("solo_acks", 64'(n_ack), 64'd20);
    chk("solo_held", 64'(held), 64'h1);
    tick(); set_ch(3, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick(); #1;

    // All four channels writing continuously: strict rotation, 2 acks each
    exp_ack = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001};
    for (int c = 0; c < 4; c++) set_ch(c, 1'b1, 1'b1, 4'hF, 32'(c * 16), 32'(c));
    #1;
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("rr_ack_%0d", k), 64'(ack), 64'(exp_ack[k]));
      tick(); #1;
    end

    // Reset in the middle of a channel-1 read
    for (int c = 0; c < 4; c++) set_ch(c, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_ch(1, 1'b1, 1'b0, 4'hF, 32'h55, 32'h0);
    tick(); #1;
    chk("rst_rd_in_valid", 64'(c_iv), 64'h1);
    chk("rst_rd_grant", 64'(grant), 64'b0010);
    tick(); #1;
    chk("rst_rd_wait_iv", 64'(c_iv), 64'h0);
    rst_n = 1'b0; #1;
    chk("rst_during_addr", 64'(c_addr32), 64'h0);
    chk("rst_during_ack", 64'(ack), 64'h0);
    tick(); #1;
    chk("rst_mid_grant", 64'(grant), 64'h0);
    chk("rst_mid_iv", 64'(c_iv), 64'h0);
    rst_n = 1'b1; set_ch(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); c_ov = 1'b1; #1;
    chk("rst_stale_resp_ack", 64'(ack), 64'h0);
    tick(); c_ov = 1'b0; #1;
    chk("rst_stale_grant", 64'(grant), 64'h0);

`ifdef SDRAM_ARB_TIMEOUT_EN
    // Read with no response: error pulse 16 cycles after in_valid
    set_ch(2, 1'b1, 1'b0, 4'hF, 32'h60, 32'h0);
    tick(); #1;
    chk("tmo_in_valid", 64'(c_iv), 64'h1);
    n_err = 0;
    for (int k = 1; k < 16; k++) begin
      tick(); #1;
      n_err += (err != 4'b0000) ? 1 : 0;
    end
    chk("tmo_no_early_err", 64'(n_err), 64'h0);
    tick(); #1;
    chk("tmo_err", 64'(err), 64'b0100);
    tick(); set_ch(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); c_ov = 1'b1; #1;
    chk("tmo_idle", 64'(grant), 64'h0);
    chk("tmo_late_ack", 64'(ack), 64'h0);
    tick(); c_ov = 1'b0;
`else
    n_err = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
